// File: rtl/treasure_result_link_pkg.sv
// Shared definitions for the treasure result link: result code layout,
// handshake FSM state encoding and small code helpers.
package treasure_result_link_pkg;

    localparam int RESULT_W = 3;

    // Shape field, bits 1:0 of a result code
    localparam logic [1:0] SHAPE_NONE   = 2'b00;
    localparam logic [1:0] SHAPE_SQUARE = 2'b01;
    localparam logic [1:0] SHAPE_TRI    = 2'b10;
    localparam logic [1:0] SHAPE_DIAM   = 2'b11;

    // Color field, bit 2 of a result code
    localparam logic COLOR_RED  = 1'b1;
    localparam logic COLOR_BLUE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_ACK   = 2'd2
    } hs_state_e;

    // A frame with no shape carries no meaningful color, so it collapses to 000.
    function automatic logic [RESULT_W-1:0] normalize_code(input logic [RESULT_W-1:0] code);
        if (code[1:0] == SHAPE_NONE) begin
            return '0;
        end
        return code;
    endfunction

    // One-hot status decode: bit0 none, bits 1..3 red shapes, bits 4..6 blue shapes.
    function automatic logic [6:0] led_decode(input logic [RESULT_W-1:0] code);
        logic [6:0] onehot;
        onehot = 7'b000_0001;
        case ({code[2], code[1:0]})
            {COLOR_RED,  SHAPE_SQUARE}: onehot = 7'b000_0010;
            {COLOR_RED,  SHAPE_TRI}:    onehot = 7'b000_0100;
            {COLOR_RED,  SHAPE_DIAM}:   onehot = 7'b000_1000;
            {COLOR_BLUE, SHAPE_SQUARE}: onehot = 7'b001_0000;
            {COLOR_BLUE, SHAPE_TRI}:    onehot = 7'b010_0000;
            {COLOR_BLUE, SHAPE_DIAM}:   onehot = 7'b100_0000;
            default:                    onehot = 7'b000_0001;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/treasure_result_link_persist_filter.sv
// result_persist_filter: normalizes per-frame codes, accepts a code once it
// has been seen on PERSIST consecutive frames, and forces the accepted code
// back to 000 when frames stop arriving for TIMEOUT_CYCLES clocks.
module result_persist_filter
    import treasure_result_link_pkg::*;
#(
    parameter int PERSIST        = 3,
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                frame_valid_i,
    input  logic [RESULT_W-1:0] frame_result_i,
    output logic [RESULT_W-1:0] accepted_o
);

    localparam int          TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]  RUN_MAX = 4'(PERSIST);

    logic [RESULT_W-1:0] cand_q, cand_d;
    logic [RESULT_W-1:0] acc_q, acc_d;
    logic [3:0]          run_q, run_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [RESULT_W-1:0] code_n;

    // Next-state: a frame always beats the timeout in the same cycle
    always_comb begin
        code_n = normalize_code(frame_result_i);
        cand_d = cand_q;
        acc_d  = acc_q;
        run_d  = run_q;
        tmo_d  = tmo_q;
        if (frame_valid_i) begin
            tmo_d = '0;
            if (code_n == cand_q) begin
                run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 4'd1;
            end else begin
                cand_d = code_n;
                run_d  = 4'd1;
            end
            if (run_d == RUN_MAX) begin
                acc_d = cand_d;
            end
        end else begin
            tmo_d = (tmo_q == TMO_MAX) ? TMO_MAX : tmo_q + 1'b1;
            if (tmo_d == TMO_MAX) begin
                acc_d  = '0;
                cand_d = '0;
                run_d  = 4'd0;
            end
        end
    end

    // Filter state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cand_q <= '0;
            acc_q  <= '0;
            run_q  <= 4'd0;
            tmo_q  <= '0;
        end else begin
            cand_q <= cand_d;
            acc_q  <= acc_d;
            run_q  <= run_d;
            tmo_q  <= tmo_d;
        end
    end

    assign accepted_o = acc_q;

endmodule

// File: rtl/treasure_result_link.sv
// treasure_result_link: filters the classifier's per-frame treasure code and
// hands the accepted code to the Arduino over a four-phase REQ/ACK handshake.
// RES_OUT is latched only when a request is first seen, so it never changes
// while the Arduino may be sampling it.
// Optional: define RESULT_LED_EN to drive LED with a one-hot decode of
// ACCEPTED plus ARD_ACK; otherwise LED is tied low.
module treasure_result_link
    import treasure_result_link_pkg::*;
#(
    parameter int PERSIST        = 3,
    parameter int TIMEOUT_CYCLES = 25000000,
    parameter int SETUP_CYCLES   = 8
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    input  logic                FRAME_VALID,
    input  logic [RESULT_W-1:0] FRAME_RESULT,
    input  logic                ARD_REQ,
    output logic [RESULT_W-1:0] RES_OUT,
    output logic                ARD_ACK,
    output logic [RESULT_W-1:0] ACCEPTED,
    output logic [7:0]          LED
);

    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);

    logic                req_meta_q;
    logic                req_s_q;
    hs_state_e           state_q;
    logic [7:0]          setup_cnt_q;
    logic [RESULT_W-1:0] res_out_q;
    logic                ack_q;

    result_persist_filter #(
        .PERSIST        (PERSIST),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_filter (
        .clk_i          (CLOCK),
        .rst_ni         (RESET_N),
        .frame_valid_i  (FRAME_VALID),
        .frame_result_i (FRAME_RESULT),
        .accepted_o     (ACCEPTED)
    );

    // Two-flop synchronizer for the asynchronous Arduino request
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
        end else begin
            req_meta_q <= ARD_REQ;
            req_s_q    <= req_meta_q;
        end
    end

    // Handshake FSM with registered RES_OUT/ARD_ACK
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            setup_cnt_q <= 8'd0;
            res_out_q   <= '0;
            ack_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= 1'b0;
                    if (req_s_q) begin
                        res_out_q   <= ACCEPTED;
                        setup_cnt_q <= SETUP_LOAD;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (!req_s_q) begin
                        state_q <= ST_IDLE;
                    end else if (setup_cnt_q == 8'd0) begin
                        ack_q   <= 1'b1;
                        state_q <= ST_ACK;
                    end else begin
                        setup_cnt_q <= setup_cnt_q - 8'd1;
                    end
                end
                ST_ACK: begin
                    if (!req_s_q) begin
                        ack_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign RES_OUT = res_out_q;
    assign ARD_ACK = ack_q;

`ifdef RESULT_LED_EN
    assign LED = {ack_q, led_decode(ACCEPTED)};
`else
    assign LED = 8'h00;
`endif

endmodule

// File: tb/tb_treasure_result_link.sv
// Testbench for treasure_result_link: directed scenarios plus randomized
// frames and handshakes, checked against a window-based reference model.
module tb_treasure_result_link;

    localparam int P = 3;
    localparam int T = 100;
    localparam int S = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_valid = 1'b0;
    logic [2:0] frame_result = 3'b000;
    logic       ard_req = 1'b0;
    logic [2:0] res_out;
    logic       ard_ack;
    logic [2:0] accepted;
    logic [7:0] led;

    int n_checks = 0;
    int n_pass   = 0;
    int txn_id   = 0;

    // Reference model: last P normalized frames since the last clear
    logic [2:0] m_win[$];
    logic [2:0] m_acc;
    int         m_idle;
    logic [2:0] m_res;
    logic [2:0] sticky;

    always #5 clk = ~clk;

    treasure_result_link #(
        .PERSIST        (P),
        .TIMEOUT_CYCLES (T),
        .SETUP_CYCLES   (S)
    ) dut (
        .CLOCK        (clk),
        .RESET_N      (rst_n),
        .FRAME_VALID  (frame_valid),
        .FRAME_RESULT (frame_result),
        .ARD_REQ      (ard_req),
        .RES_OUT      (res_out),
        .ARD_ACK      (ard_ack),
        .ACCEPTED     (accepted),
        .LED          (led)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_win.delete();
        m_acc  = 3'b000;
        m_idle = 0;
        m_res  = 3'b000;
    endtask

    task automatic model_edge(input bit fv, input logic [2:0] code);
        logic [2:0] n;
        bit         same;
        if (fv) begin
            n = (code[1:0] == 2'b00) ? 3'b000 : code;
            m_win.push_back(n);
            if (m_win.size() > P) void'(m_win.pop_front());
            m_idle = 0;
            if (m_win.size() == P) begin
                same = 1'b1;
                foreach (m_win[i]) if (m_win[i] != m_win[0]) same = 1'b0;
                if (same) m_acc = m_win[0];
            end
        end else begin
            m_idle = (m_idle >= T) ? T : m_idle + 1;
            if (m_idle == T) begin
                m_win.delete();
                m_acc = 3'b000;
            end
        end
    endtask

    // One clock: inputs applied at negedge, model advanced at posedge, checked at negedge
    task automatic tick(input bit fv, input logic [2:0] code);
        frame_valid  = fv;
        frame_result = code;
        @(posedge clk);
        model_edge(fv, code);
        @(negedge clk);
        frame_valid = 1'b0;
        chk("accepted", 32'(accepted), 32'(m_acc));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_frame(output bit fv, output logic [2:0] code);
        if ($urandom_range(0, 3) == 0) sticky = 3'($urandom_range(0, 7));
        fv   = ($urandom_range(0, 2) == 0);
        code = sticky;
    endtask

    // One request held high for 'hold' edges; frames random or forced to mid_code from edge 4
    task automatic txn(input int hold, input bit rnd, input bit mid_en, input logic [2:0] mid_code);
        logic [2:0] prev_res;
        logic [2:0] latched;
        bit         fv;
        logic [2:0] code;
        bit         exp_ack;
        bit         saw_ack;
        prev_res = m_res;
        latched  = m_res;
        saw_ack  = 1'b0;
        ard_req  = 1'b1;
        for (int e = 1; e <= hold + 6; e++) begin
            if (e == hold + 1) ard_req = 1'b0;
            fv = 1'b0;
            code = 3'b000;
            if (rnd) rand_frame(fv, code);
            if (mid_en && e >= 4) begin
                fv = 1'b1;
                code = mid_code;
            end
            if (e == 3) latched = m_acc;
            tick(fv, code);
            exp_ack = (hold >= S + 1) && (e >= 3 + S) && (e < hold + 3);
            saw_ack = saw_ack | ard_ack;
            chk("ard_ack", 32'(ard_ack), 32'(exp_ack));
            chk("res_out", 32'(res_out), 32'((e >= 3) ? latched : prev_res));
        end
        m_res = latched;
        txn_id++;
        $display("txn %0d: hold=%0d res_out=%0h ack_seen=%0d", txn_id, hold, res_out, saw_ack);
    endtask

    initial begin
        model_clear();
        sticky = 3'b000;

        // Reset state
        @(negedge clk);
        chk("rst_res_out", 32'(res_out), 32'h0);
        chk("rst_ack", 32'(ard_ack), 32'h0);
        chk("rst_accepted", 32'(accepted), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        do_reset();

        // Three 101 frames: accepted only after the third
        tick(1'b1, 3'b101); tick(1'b0, 3'b000);
        tick(1'b1, 3'b101); tick(1'b0, 3'b000);
        chk("persist_two", 32'(accepted), 32'h0);
        tick(1'b1, 3'b101);
        chk("persist_three", 32'(accepted), 32'h5);

        // Broken run restarts the count
        do_reset();
        tick(1'b1, 3'b101); tick(1'b1, 3'b101); tick(1'b1, 3'b110);
        tick(1'b1, 3'b101); tick(1'b1, 3'b101);
        chk("broken_run", 32'(accepted), 32'h0);
        tick(1'b1, 3'b101);
        chk("sixth_frame", 32'(accepted), 32'h5);

        // 011 and 111 are distinct candidates
        tick(1'b1, 3'b011); tick(1'b1, 3'b011); tick(1'b1, 3'b011);
        chk("acc_011", 32'(accepted), 32'h3);
        tick(1'b1, 3'b111); tick(1'b1, 3'b111);
        chk("111_pending", 32'(accepted), 32'h3);
        tick(1'b1, 3'b111);
        chk("acc_111", 32'(accepted), 32'h7);

        // 100 and 000 both mean no treasure
        tick(1'b1, 3'b100); tick(1'b1, 3'b000); tick(1'b1, 3'b100);
        chk("normalize_none", 32'(accepted), 32'h0);

        // Timeout at exactly T idle cycles
        do_reset();
        tick(1'b1, 3'b110); tick(1'b1, 3'b110); tick(1'b1, 3'b110);
        for (int i = 0; i < T - 1; i++) tick(1'b0, 3'b000);
        chk("tmo_before", 32'(accepted), 32'h6);
        tick(1'b0, 3'b000);
        chk("tmo_at", 32'(accepted), 32'h0);

        // A frame landing on the timeout cycle wins
        tick(1'b1, 3'b110); tick(1'b1, 3'b110); tick(1'b1, 3'b110);
        for (int i = 0; i < T - 1; i++) tick(1'b0, 3'b000);
        tick(1'b1, 3'b110);
        chk("tmo_frame_wins", 32'(accepted), 32'h6);
        tick(1'b0, 3'b000);
        chk("tmo_cleared", 32'(accepted), 32'h6);

        // Handshake with ACCEPTED changing mid-transaction
        do_reset();
        tick(1'b1, 3'b011); tick(1'b1, 3'b011); tick(1'b1, 3'b011);
        txn(S + 6, 1'b0, 1'b1, 3'b101);
        chk("hs_res_held", 32'(res_out), 32'h3);
        chk("hs_acc_moved", 32'(accepted), 32'h5);

        // Aborted short request
        txn(4, 1'b0, 1'b0, 3'b000);

        // Next request picks up the new code
        txn(S + 2, 1'b0, 1'b0, 3'b000);
        chk("hs_new_code", 32'(res_out), 32'h5);

        // Reset while in ACK drops outputs without a clock edge
        ard_req = 1'b1;
        for (int e = 1; e <= S + 4; e++) tick(1'b0, 3'b000);
        chk("pre_rst_ack", 32'(ard_ack), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ack", 32'(ard_ack), 32'h0);
        chk("async_res", 32'(res_out), 32'h0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Request still high: a fresh transaction follows reset release
        txn(S + 5, 1'b0, 1'b0, 3'b000);

        // Randomized frames and handshakes
        for (int k = 0; k < 30; k++) begin
            int gap;
            bit fv;
            logic [2:0] code;
            gap = $urandom_range(0, 12);
            for (int g = 0; g < gap; g++) begin
                rand_frame(fv, code);
                tick(fv, code);
            end
            txn($urandom_range(2, S + 12), 1'b1, 1'b0, 3'b000);
        end

        // Long random idle stretch exercises the timeout with random history
        for (int g = 0; g < 3 * T; g++) begin
            bit fv;
            logic [2:0] code;
            rand_frame(fv, code);
            if (g > T) fv = 1'b0;
            tick(fv, code);
        end
        chk("final_led", 32'(led), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/treasure_result_link.md
Name: treasure_result_link

Overview:
- Downstream of the camera downsampler/treasure classifier, in the CLOCK_50 domain.
- Consumes the per-frame 3-bit treasure code and its frame-end strobe.
- Applies persistence filtering and a staleness timeout.
- Presents the accepted code to the Arduino over a four-phase REQ/ACK handshake on GPIO, so the robot never samples a code that is glitching or mid-update.

Parameters:
- PERSIST, 3: consecutive identical frames required before a code is accepted (legal range 1..15).
- TIMEOUT_CYCLES, 25000000: CLOCK cycles without FRAME_VALID before the accepted code is forced to 3'b000 (0.5 s at 50 MHz).
- SETUP_CYCLES, 8: cycles RES_OUT is held stable before ARD_ACK rises (legal range 1..255).

Ports:
- CLOCK, input, 1: system clock, CLOCK_50.
- RESET_N, input, 1: asynchronous active-low reset, driven from KEY[0].
- FRAME_VALID, input, 1: one-cycle pulse at frame end, already synchronized to CLOCK.
- FRAME_RESULT, input, 3: code for that frame.
  - Bit 2: color, 1 = red, 0 = blue.
  - Bits 1:0: shape, 00 = none, 01 = square, 10 = triangle, 11 = diamond.
- ARD_REQ, input, 1: request from Arduino; asynchronous.
- RES_OUT, output, 3: code presented to Arduino; drives GPIO_0_D[33], [31], [29].
- ARD_ACK, output, 1: acknowledge to Arduino.
- ACCEPTED, output, 3: current filtered code, for debug.
- LED, output, 8: status LEDs; see Optional Feature.

Behaviour:
- Reset (asynchronous, RESET_N low) forces:
  - RES_OUT = 0, ARD_ACK = 0, ACCEPTED = 0, LED = 0.
  - Candidate register = 0, run counter = 0, timeout counter = 0.
  - FSM = IDLE, ARD_REQ synchronizer flops = 0.
- Normalization: any FRAME_RESULT with bits 1:0 == 00 is treated as 3'b000 before comparison; the color bit is meaningless when no shape is present.
- Persistence filter, evaluated on FRAME_VALID only:
  - If the normalized code equals the candidate: run = min(run+1, PERSIST).
  - Otherwise: candidate = code, run = 1.
  - When run reaches PERSIST, ACCEPTED = candidate in the same cycle as that FRAME_VALID, so ACCEPTED is visible on the next edge.
  - With PERSIST = 1, every frame is accepted immediately.
- Timeout:
  - The counter clears on every FRAME_VALID and otherwise increments, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: ACCEPTED = 0, candidate = 0, run = 0.
  - If FRAME_VALID arrives in the same cycle, FRAME_VALID wins: the counter clears and the filter update applies.
- ARD_REQ passes through a 2-flop synchronizer; the FSM uses only the synchronized level REQ_S.
- Handshake FSM:
  - IDLE: ARD_ACK = 0. When REQ_S = 1, latch RES_OUT <= ACCEPTED, load the setup counter, go to SETUP.
  - SETUP: RES_OUT frozen; count down SETUP_CYCLES. At zero, ARD_ACK <= 1 and go to ACK.
    - If REQ_S drops during SETUP (aborted request), return to IDLE with ARD_ACK still 0.
  - ACK: hold ARD_ACK = 1 and RES_OUT. When REQ_S = 0, ARD_ACK <= 0 and go to IDLE.
- RES_OUT changes only on the IDLE->SETUP transition; it is otherwise held, including between transactions.
- ACCEPTED keeps updating during a transaction but does not affect RES_OUT until the next request.
- Latency:
  - ARD_REQ rising to ARD_ACK rising = 2 (synchronizer) + 1 + SETUP_CYCLES CLOCK edges.
  - ARD_REQ falling to ARD_ACK falling = 3 edges.
- Reset mid-transaction: ARD_ACK drops asynchronously and the FSM returns to IDLE. If REQ is still high after reset release, a new transaction starts.

Optional Feature:
- Macro: RESULT_LED_EN.
- Defined:
  - LED[6:0] = one-hot of ACCEPTED: bit0 = none; bits 1..3 = red square, red triangle, red diamond; bits 4..6 = blue square, blue triangle, blue diamond.
  - LED[7] = ARD_ACK.
- Undefined: LED tied to 8'h00 and no decode logic is synthesized.

Decomposition:
- Shared package:
  - Shape localparams: SHAPE_NONE 2'b00, SHAPE_SQUARE 2'b01, SHAPE_TRI 2'b10, SHAPE_DIAM 2'b11.
  - COLOR_RED 1'b1 / COLOR_BLUE 1'b0.
  - FSM state encodings: IDLE, SETUP, ACK.
  - Result width of 3.
- One sub-module, result_persist_filter: the normalization, run counter, candidate register and timeout, outputting ACCEPTED. The handshake FSM and synchronizer stay in the top.

Test Plan:
- Reset, then 3 FRAME_VALID pulses with FRAME_RESULT = 3'b101 -> ACCEPTED = 3'b101 one edge after the third pulse; it stays 0 after the first two.
- Frames 101, 101, 110, 101, 101, 101 -> ACCEPTED = 0 until the sixth frame, then 3'b101.
  - Then frames 011, 111 -> both normalize to 3'b011/3'b111; 011 and 111 count as different candidates.
- ACCEPTED = 3'b110, then no FRAME_VALID for TIMEOUT_CYCLES (use 100 in sim) -> ACCEPTED = 0 at cycle 100.
  - FRAME_VALID landing exactly at cycle 100 keeps the filter update instead.
- ACCEPTED = 3'b011, raise ARD_REQ -> RES_OUT = 3'b011 at edge 3, ARD_ACK = 1 at edge 3 + SETUP_CYCLES.
  - Change ACCEPTED to 3'b101 mid-transaction -> RES_OUT stays 3'b011.
  - Drop ARD_REQ -> ARD_ACK = 0 after 3 edges.
- ARD_REQ pulsed high for 4 cycles with SETUP_CYCLES = 8 -> ARD_ACK never asserts; FSM returns to IDLE.
- Assert RESET_N low while in ACK -> ARD_ACK and RES_OUT drop to 0 immediately, without waiting for a clock edge.
  - With RESULT_LED_EN defined, LED = 8'h01 after reset.
